// File: rtl/shift_sequencer_arb_pkg.sv
// Shared definitions for the shift sequencer: shift-register select codes
// and the sequencer FSM state encoding.
package shift_sequencer_arb_pkg;

    // Select codes driven to the external shift register
    typedef enum logic [1:0] {
        SEL_HOLD  = 2'b00,
        SEL_RIGHT = 2'b01,
        SEL_LEFT  = 2'b10,
        SEL_LOAD  = 2'b11
    } sh_sel_e;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

endpackage

// File: rtl/shift_arb_rr2.sv
// Two-requester arbiter. Requests are first qualified by the eligibility
// mask. On a tie the requester selected by pointer wins. Output is one-hot,
// or all zero when nothing is eligible.
module shift_arb_rr2 (
    input  logic [1:0] req,
    input  logic       pointer,
    input  logic [1:0] mask,
    output logic [1:0] winner
);

    logic [1:0] elig;

    // Pick a single winner among the eligible requests
    always_comb begin
        elig   = req & mask;
        winner = 2'b00;
        case (elig)
            2'b01:   winner = 2'b01;
            2'b10:   winner = 2'b10;
            2'b11:   winner = pointer ? 2'b10 : 2'b01;
            default: winner = 2'b00;
        endcase
    end

endmodule

// File: rtl/shift_sequencer_arb.sv
// Shift sequencer with two requesters. Grants one job at a time, loads the
// external shift register, shifts it AMT times in the requested direction
// and captures the result.
// Optional macro SHIFT_ARB_RR_EN: round-robin arbitration between the two
// requesters; undefined gives fixed priority with requester 0 winning ties.
//
// Handshake: a requester holds REQ high (level) until it is granted; the
// operands are sampled at the grant edge only. DONE(i) pulses for one
// cycle after the job, during which requester i cannot be granted again;
// the requester drops REQ in the cycle after DONE(i). Dropping REQ earlier
// does not cancel a job that is already granted.
module shift_sequencer_arb
    import shift_sequencer_arb_pkg::*;
#(
    parameter int DW = 32,
    parameter int SW = 5
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ0,
    input  logic          REQ1,
    input  logic [DW-1:0] DATA0,
    input  logic [DW-1:0] DATA1,
    input  logic [SW-1:0] AMT0,
    input  logic [SW-1:0] AMT1,
    input  logic          LNR0,
    input  logic          LNR1,
    output logic [1:0]    GNT,
    output logic          DONE0,
    output logic          DONE1,
    output logic [DW-1:0] RESULT,
    output logic          BUSY,
    output logic [DW-1:0] SH_DATA,
    output logic [1:0]    SH_SEL,
    input  logic [DW-1:0] SH_RESULT
);

    state_e        state;
    state_e        next_state;
    logic [SW-1:0] cnt;
    logic [DW-1:0] op_data;
    logic          op_lnr;
    logic [1:0]    gnt;
    logic [1:0]    done_q;
    logic [DW-1:0] result;
    logic          ptr;
    logic [1:0]    win;
    logic          take;
    logic [1:0]    sel;

    // A requester whose DONE is showing is masked for that cycle
    shift_arb_rr2 u_arb (
        .req     ({REQ1, REQ0}),
        .pointer (ptr),
        .mask    (~done_q),
        .winner  (win)
    );

    assign take = (state == ST_IDLE) && (win != 2'b00);

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Next-state and shift-register select decode
    always_comb begin
        next_state = state;
        sel        = SEL_HOLD;
        case (state)
            ST_IDLE: begin
                if (take) next_state = ST_LOAD;
            end
            ST_LOAD: begin
                sel        = SEL_LOAD;
                next_state = (cnt != '0) ? ST_SHIFT : ST_DONE;
            end
            ST_SHIFT: begin
                sel = op_lnr ? SEL_LEFT : SEL_RIGHT;
                // Counter hits zero on this edge: that was the last shift
                if (cnt == SW'(1)) next_state = ST_DONE;
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Job operands, counter, grant, completion pulse and result capture
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt     <= '0;
            op_data <= '0;
            op_lnr  <= 1'b0;
            gnt     <= 2'b00;
            done_q  <= 2'b00;
            result  <= '0;
        end else begin
            done_q <= 2'b00;
            if (take) begin
                op_data <= win[1] ? DATA1 : DATA0;
                cnt     <= win[1] ? AMT1  : AMT0;
                op_lnr  <= win[1] ? LNR1  : LNR0;
                gnt     <= win;
            end
            if (state == ST_SHIFT) cnt <= cnt - SW'(1);
            if (state == ST_DONE) begin
                result <= SH_RESULT;
                gnt    <= 2'b00;
                done_q <= gnt;
            end
        end
    end

    // Round-robin pointer: after a grant it points at the other requester
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr <= 1'b0;
        end else begin
`ifdef SHIFT_ARB_RR_EN
            if (take) ptr <= win[0];
`else
            ptr <= 1'b0;
`endif
        end
    end

    assign GNT     = gnt;
    assign DONE0   = done_q[0];
    assign DONE1   = done_q[1];
    assign RESULT  = result;
    assign BUSY    = (state != ST_IDLE);
    assign SH_DATA = op_data;
    assign SH_SEL  = sel;

endmodule

// File: tb/tb_shift_sequencer_arb.sv
// Bench for shift_sequencer_arb paired with a 32-bit shift register model.
// Expected grants, timing and results come from the arbitration rules and
// plain shift arithmetic.
module tb_shift_sequencer_arb;

    localparam int DW = 32;
    localparam int SW = 5;

    logic          CLK;
    logic          RST;
    logic          REQ0, REQ1;
    logic [DW-1:0] DATA0, DATA1;
    logic [SW-1:0] AMT0, AMT1;
    logic          LNR0, LNR1;
    logic [1:0]    GNT;
    logic          DONE0, DONE1;
    logic [DW-1:0] RESULT;
    logic          BUSY;
    logic [DW-1:0] SH_DATA;
    logic [1:0]    SH_SEL;
    logic [DW-1:0] SH_RESULT;

    int checks = 0;
    int errors = 0;
    int model_ptr = 0;
    int pulse_who = -1;

    shift_sequencer_arb #(.DW(DW), .SW(SW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ0      (REQ0),
        .REQ1      (REQ1),
        .DATA0     (DATA0),
        .DATA1     (DATA1),
        .AMT0      (AMT0),
        .AMT1      (AMT1),
        .LNR0      (LNR0),
        .LNR1      (LNR1),
        .GNT       (GNT),
        .DONE0     (DONE0),
        .DONE1     (DONE1),
        .RESULT    (RESULT),
        .BUSY      (BUSY),
        .SH_DATA   (SH_DATA),
        .SH_SEL    (SH_SEL),
        .SH_RESULT (SH_RESULT)
    );

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // External shift register: hold / right / left / load
    logic [DW-1:0] sr = '0;
    always @(posedge CLK) begin
        case (SH_SEL)
            2'b01:   sr <= sr >> 1;
            2'b10:   sr <= sr << 1;
            2'b11:   sr <= SH_DATA;
            default: sr <= sr;
        endcase
    end
    assign SH_RESULT = sr;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_gnt"},    {30'd0, GNT},            '0);
        check({tag, "_done"},   {30'd0, DONE1, DONE0},   '0);
        check({tag, "_busy"},   {31'd0, BUSY},           '0);
        check({tag, "_shsel"},  {30'd0, SH_SEL},         '0);
        check({tag, "_shdata"}, SH_DATA,                 '0);
        check({tag, "_result"}, RESULT,                  '0);
    endtask

    // Scramble operands and optionally drop the winner's REQ mid-job
    task automatic scramble(input int w, input bit drop_mid);
        DATA0 = $urandom; DATA1 = $urandom;
        AMT0  = SW'($urandom); AMT1 = SW'($urandom);
        LNR0  = 1'($urandom);  LNR1 = 1'($urandom);
        if (drop_mid) begin
            if (w == 0) REQ0 = 1'b0; else REQ1 = 1'b0;
        end
    endtask

    // One complete job starting from the current REQ/operand inputs.
    // Returns the requester that the arbitration rules select.
    task automatic run_job(input bit drop_mid, output int w);
        logic [1:0]    elig;
        logic [DW-1:0] d;
        logic [SW-1:0] a;
        logic          l;
        logic [DW-1:0] exp_r;
        elig = {REQ1, REQ0};
        if (pulse_who >= 0) elig[pulse_who] = 1'b0;
        w = (elig == 2'b11) ? model_ptr : (elig[1] ? 1 : 0);
        d = (w == 1) ? DATA1 : DATA0;
        a = (w == 1) ? AMT1  : AMT0;
        l = (w == 1) ? LNR1  : LNR0;
        exp_r = l ? (d << a) : (d >> a);

        tick();
        pulse_who = -1;
`ifdef SHIFT_ARB_RR_EN
        model_ptr = 1 - w;
`endif
        check("grant_gnt",    {30'd0, GNT},          DW'(1 << w));
        check("load_shsel",   {30'd0, SH_SEL},       DW'(3));
        check("load_shdata",  SH_DATA,               d);
        check("load_busy",    {31'd0, BUSY},         DW'(1));
        scramble(w, drop_mid);

        for (int k = 0; k < int'(a); k++) begin
            tick();
            check("shift_shsel", {30'd0, SH_SEL},        l ? DW'(2) : DW'(1));
            check("shift_gnt",   {30'd0, GNT},           DW'(1 << w));
            check("shift_done",  {30'd0, DONE1, DONE0},  '0);
            check("shift_data",  SH_DATA,                d);
        end

        tick();
        check("donest_shsel", {30'd0, SH_SEL},       '0);
        check("donest_busy",  {31'd0, BUSY},         DW'(1));
        check("donest_done",  {30'd0, DONE1, DONE0}, '0);

        tick();
        check("pulse_done",   {30'd0, DONE1, DONE0}, DW'(1 << w));
        check("pulse_result", RESULT,                exp_r);
        check("pulse_gnt",    {30'd0, GNT},          '0);
        check("pulse_busy",   {31'd0, BUSY},         '0);
        pulse_who = w;
        // Requester withdraws in the cycle after its DONE
        if (w == 0) REQ0 = 1'b0; else REQ1 = 1'b0;
    endtask

    task automatic idle_tick();
        REQ0 = 1'b0;
        REQ1 = 1'b0;
        tick();
        pulse_who = -1;
        check("idle_done", {30'd0, DONE1, DONE0}, '0);
        check("idle_busy", {31'd0, BUSY},         '0);
    endtask

    initial begin
        int w;
        int w2;
        RST = 1'b1;
        REQ0 = 1'b0; REQ1 = 1'b0;
        DATA0 = '0; DATA1 = '0; AMT0 = '0; AMT1 = '0; LNR0 = 1'b0; LNR1 = 1'b0;
        #2;
        check_reset_values("rst_async");
        tick(); tick();
        check_reset_values("rst_hold");

        // Release reset with a request already waiting
        RST = 1'b0;
        REQ0 = 1'b1; DATA0 = 32'h0000_0004; AMT0 = 5'd2; LNR0 = 1'b1;
        run_job(1'b0, w);
        idle_tick();

        // Long right shift from requester 1
        REQ1 = 1'b1; DATA1 = 32'h8000_0000; AMT1 = 5'd31; LNR1 = 1'b0;
        run_job(1'b0, w);
        idle_tick();

        // Zero shift count skips the shifting phase
        REQ0 = 1'b1; DATA0 = 32'hDEAD_BEEF; AMT0 = 5'd0; LNR0 = 1'b1;
        run_job(1'b1, w);
        idle_tick();

        // Four ties: round-robin alternates, fixed priority keeps requester 0
        for (int r = 0; r < 4; r++) begin
            REQ0 = 1'b1; REQ1 = 1'b1;
            DATA0 = $urandom; DATA1 = $urandom;
            AMT0 = SW'($urandom_range(0, 6)); AMT1 = SW'($urandom_range(0, 6));
            LNR0 = 1'($urandom); LNR1 = 1'($urandom);
            run_job(1'b0, w);
            idle_tick();
        end

        // Loser of a tie stays pending and is served right after
        REQ0 = 1'b1; REQ1 = 1'b1;
        DATA0 = 32'h0000_00F0; AMT0 = 5'd4; LNR0 = 1'b0;
        DATA1 = 32'h0000_000F; AMT1 = 5'd4; LNR1 = 1'b1;
        run_job(1'b0, w);
        run_job(1'b1, w2);
        check("pending_other", DW'(w + w2), DW'(1));
        idle_tick();

        // Reset in the middle of a ten-shift job
        REQ0 = 1'b1; DATA0 = 32'h1234_5678; AMT0 = 5'd10; LNR0 = 1'b1;
        tick();
        check("abort_gnt", {30'd0, GNT}, DW'(1));
        REQ0 = 1'b0;
        tick(); tick(); tick();
        check("abort_shift", {30'd0, SH_SEL}, DW'(2));
        #2 RST = 1'b1;
        #1;
        check_reset_values("abort_async");
        tick();
        RST = 1'b0;
        model_ptr = 0;
        pulse_who = -1;
        for (int k = 0; k < 12; k++) begin
            tick();
            check("abort_nodone", {30'd0, DONE1, DONE0}, '0);
        end
        REQ0 = 1'b1; REQ1 = 1'b1;
        DATA0 = 32'h0000_0001; AMT0 = 5'd3; LNR0 = 1'b1;
        DATA1 = 32'h0000_0100; AMT1 = 5'd3; LNR1 = 1'b0;
        run_job(1'b0, w);
        run_job(1'b0, w2);
        idle_tick();

        // Random jobs
        for (int n = 0; n < 30; n++) begin
            int pick;
            pick = $urandom_range(1, 3);
            REQ0 = pick[0]; REQ1 = pick[1];
            DATA0 = $urandom; DATA1 = $urandom;
            AMT0 = SW'($urandom); AMT1 = SW'($urandom);
            LNR0 = 1'($urandom); LNR1 = 1'($urandom);
            run_job(1'($urandom), w);
            if (REQ0 || REQ1) run_job(1'($urandom), w2);
            idle_tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
